// File: rtl/if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// if_id_pipe_reg
//
// Purpose: IF/ID pipeline register between fetch and decode. This is a
// valid/ready stage with these features:
//   - back-pressure (stall) from decode
//   - synchronous flush that injects NOP_INST
//   - an optional skid entry
//   - a saturating stall-cycle counter
//
// Optional feature macro: IFID_SKID_EN
//   Defined  : a second (skid) entry S is compiled in. in_ready comes
//              straight from a flop, and two beats can be held.
//   Undefined: only the main entry M exists, and
//              in_ready = !out_valid || out_ready.
//
// Parameters:
//   PC_W     width of the PC+4 field
//   INST_W   width of the instruction field
//   NOP_INST instruction presented whenever out_valid is low
//   CNT_W    width of the stall counter
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   flush                  squashes every held beat at the next edge
//   in_valid / in_ready    fetch-side handshake
//   in_pcadd4, in_inst     fetched beat
//   out_valid / out_ready  decode-side handshake (out_ready low = stall)
//   out_pcadd4, out_inst   registered beat (out_inst = NOP_INST when invalid)
//   stall_cnt              saturating count of out_valid && !out_ready cycles
// ---------------------------------------------------------------------------
module if_id_pipe_reg #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pcadd4,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pcadd4,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Main entry M, which drives the out_* ports
  logic              mValid_q, mValid_d;
  logic [PC_W-1:0]   mPc_q, mPc_d;
  logic [INST_W-1:0] mInst_q, mInst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic accept;
  logic mLoad;
  logic stalled;

`ifdef IFID_SKID_EN
  // Skid entry S, plus a dedicated flop holding !S_valid for in_ready
  logic              sValid_q, sValid_d;
  logic [PC_W-1:0]   sPc_q, sPc_d;
  logic [INST_W-1:0] sInst_q, sInst_d;
  logic              inReady_q, inReady_d;

  assign in_ready = inReady_q;
`else
  assign in_ready = !mValid_q || out_ready;
`endif

  assign accept  = in_valid && in_ready;
  assign mLoad   = !mValid_q || out_ready;
  assign stalled = mValid_q && !out_ready;

  // Next-state logic for both entries and the stall counter
  always_comb begin
    mValid_d = mValid_q;
    mPc_d    = mPc_q;
    mInst_d  = mInst_q;
    cnt_d    = cnt_q;
`ifdef IFID_SKID_EN
    sValid_d = sValid_q;
    sPc_d    = sPc_q;
    sInst_d  = sInst_q;
`endif

    // The counter keeps counting through a flush; only reset clears it
    if (stalled && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (flush) begin
      // Squash everything, including a beat handshaken this cycle.
      // The PC still tracks fetch so that decode sees the newest PC+4.
      mValid_d = 1'b0;
      mInst_d  = NOP_INST;
      if (in_valid) begin
        mPc_d = in_pcadd4;
      end
`ifdef IFID_SKID_EN
      sValid_d = 1'b0;
`endif
    end else begin
`ifdef IFID_SKID_EN
      if (mLoad) begin
        if (sValid_q) begin
          // in_ready was low, so no new beat can be accepted here
          mValid_d = 1'b1;
          mPc_d    = sPc_q;
          mInst_d  = sInst_q;
          sValid_d = 1'b0;
        end else if (accept) begin
          mValid_d = 1'b1;
          mPc_d    = in_pcadd4;
          mInst_d  = in_inst;
        end else begin
          mValid_d = 1'b0;
          mInst_d  = NOP_INST;
        end
      end else if (accept) begin
        // M is stalled and S is free (accept implies S empty)
        sValid_d = 1'b1;
        sPc_d    = in_pcadd4;
        sInst_d  = in_inst;
      end
`else
      if (mLoad) begin
        if (accept) begin
          mValid_d = 1'b1;
          mPc_d    = in_pcadd4;
          mInst_d  = in_inst;
        end else begin
          mValid_d = 1'b0;
          mInst_d  = NOP_INST;
        end
      end
`endif
    end
  end

`ifdef IFID_SKID_EN
  assign inReady_d = !sValid_d;
`endif

  // State registers, with synchronous reset that has highest priority
  always_ff @(posedge clk) begin
    if (rst) begin
      mValid_q  <= 1'b0;
      mPc_q     <= '0;
      mInst_q   <= NOP_INST;
      cnt_q     <= '0;
`ifdef IFID_SKID_EN
      sValid_q  <= 1'b0;
      sPc_q     <= '0;
      sInst_q   <= NOP_INST;
      inReady_q <= 1'b1;
`endif
    end else begin
      mValid_q  <= mValid_d;
      mPc_q     <= mPc_d;
      mInst_q   <= mInst_d;
      cnt_q     <= cnt_d;
`ifdef IFID_SKID_EN
      sValid_q  <= sValid_d;
      sPc_q     <= sPc_d;
      sInst_q   <= sInst_d;
      inReady_q <= inReady_d;
`endif
    end
  end

  assign out_valid  = mValid_q;
  assign out_pcadd4 = mPc_q;
  assign out_inst   = mInst_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Directed testbench for if_id_pipe_reg. The DUT is built with CNT_W=4 so
// that counter saturation at 15 is reachable. Expectations that differ
// between builds are selected with IFID_SKID_EN.
// ---------------------------------------------------------------------------
module tb_if_id_pipe_reg;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pcadd4;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pcadd4;
  logic [31:0] out_inst;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int expCnt;

  if_id_pipe_reg #(
    .PC_W(32), .INST_W(32), .NOP_INST(32'h0000_0000), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pcadd4(in_pcadd4), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pcadd4(out_pcadd4), .out_inst(out_inst),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge and sample 1 time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid  = v;
    in_inst   = inst;
    in_pcadd4 = pc;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick; tick;
    rst = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_inst got=%h want=00000000", out_inst); end
    total++; if (out_pcadd4 !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=00000000", out_pcadd4); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_streaming;
    logic [31:0] insts [4];
    insts[0] = 32'h11; insts[1] = 32'h22; insts[2] = 32'h33; insts[3] = 32'h44;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, insts[i], 32'((i + 1) * 4));
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_in_ready[%0d] got=%0b want=1", i, in_ready); end
      tick;
      total++; if (out_valid !== 1'b1 || out_inst !== insts[i] || out_pcadd4 !== 32'((i + 1) * 4)) begin
        bad++; $display("[TB] FAIL stream_beat[%0d] got=%0b/%h/%0d want=1/%h/%0d", i, out_valid, out_inst, out_pcadd4, insts[i], (i + 1) * 4);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick;
    total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL stream_drain got=%0b/%h want=0/00000000", out_valid, out_inst); end
  endtask

  task automatic test_stall;
    out_ready = 1'b1;
    drive(1'b1, 32'hAA, 32'd100);
    tick;
    out_ready = 1'b0;
    // First stalled cycle: fetch offers 0xBB
    drive(1'b1, 32'hBB, 32'd104);
`ifdef IFID_SKID_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_in_ready0 got=%0b want=1", in_ready); end
    tick;
    drive(1'b1, 32'hCC, 32'd108);
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready0 got=%0b want=0", in_ready); end
    tick;
`endif
    for (int k = 1; k < 3; k++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready%0d got=%0b want=0", k, in_ready); end
      tick;
    end
    total++; if (out_valid !== 1'b1 || out_inst !== 32'hAA || out_pcadd4 !== 32'd100) begin
      bad++; $display("[TB] FAIL stall_hold got=%0b/%h/%0d want=1/000000aa/100", out_valid, out_inst, out_pcadd4);
    end
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("[TB] FAIL stall_cnt got=%0d want=3", stall_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_in_ready_end got=%0b want=0", in_ready); end
    // Release: 0xBB then 0xCC must follow 0xAA
    out_ready = 1'b1;
`ifdef IFID_SKID_EN
    drive(1'b1, 32'hCC, 32'd108);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_in_ready1 got=%0b want=0", in_ready); end
`else
    drive(1'b1, 32'hBB, 32'd104);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready1 got=%0b want=1", in_ready); end
`endif
    tick;
    total++; if (out_valid !== 1'b1 || out_inst !== 32'hBB || out_pcadd4 !== 32'd104) begin
      bad++; $display("[TB] FAIL release_bb got=%0b/%h/%0d want=1/000000bb/104", out_valid, out_inst, out_pcadd4);
    end
    drive(1'b1, 32'hCC, 32'd108);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready2 got=%0b want=1", in_ready); end
    tick;
    total++; if (out_valid !== 1'b1 || out_inst !== 32'hCC || out_pcadd4 !== 32'd108) begin
      bad++; $display("[TB] FAIL release_cc got=%0b/%h/%0d want=1/000000cc/108", out_valid, out_inst, out_pcadd4);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick;
    total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL release_drain got=%0b/%h want=0/00000000", out_valid, out_inst); end
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("[TB] FAIL release_cnt got=%0d want=3", stall_cnt); end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive(1'b1, 32'h55, 32'd200);
    tick;
    // Stall one cycle so that the skid build captures 0x57 into S
    out_ready = 1'b0;
    drive(1'b1, 32'h57, 32'd204);
    tick;
    total++; if (out_inst !== 32'h55) begin bad++; $display("[TB] FAIL flush_pre_inst got=%h want=00000055", out_inst); end
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h66, 32'd208);
    tick;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL flush_bubble got=%0b/%h want=0/00000000", out_valid, out_inst); end
    total++; if (out_pcadd4 !== 32'd208) begin bad++; $display("[TB] FAIL flush_pc got=%0d want=208", out_pcadd4); end
    total++; if (stall_cnt !== 4'd4) begin bad++; $display("[TB] FAIL flush_cnt got=%0d want=4", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready got=%0b want=1", in_ready); end
    for (int k = 0; k < 2; k++) begin
      tick;
      total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL flush_no_stale[%0d] got=%0b/%h want=0/00000000", k, out_valid, out_inst); end
    end
    // A flush with in_valid low leaves the PC field unchanged
    drive(1'b1, 32'h77, 32'd300);
    tick;
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h77) begin bad++; $display("[TB] FAIL flush_reload got=%0b/%h want=1/00000077", out_valid, out_inst); end
    flush = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick;
    flush = 1'b0;
    total++; if (out_valid !== 1'b0 || out_pcadd4 !== 32'd300) begin bad++; $display("[TB] FAIL flush_pc_hold got=%0b/%0d want=0/300", out_valid, out_pcadd4); end
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    drive(1'b1, 32'h88, 32'd400);
    tick;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    expCnt = 4;
    for (int k = 0; k < 20; k++) begin
      tick;
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      total++; if (stall_cnt !== 4'(expCnt)) begin bad++; $display("[TB] FAIL sat_cnt[%0d] got=%0d want=%0d", k, stall_cnt, expCnt); end
    end
    total++; if (out_valid !== 1'b1 || out_inst !== 32'h88) begin bad++; $display("[TB] FAIL sat_hold got=%0b/%h want=1/00000088", out_valid, out_inst); end
  endtask

  task automatic test_reset_mid;
    // Still stalled on 0x88; the skid build captures 0x99 into S
    drive(1'b1, 32'h99, 32'd500);
    tick;
    rst = 1'b1;
    drive(1'b1, 32'hAB, 32'd504);
    tick;
    total++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pcadd4 !== 32'h0) begin
      bad++; $display("[TB] FAIL rstmid_out got=%0b/%h/%0d want=0/00000000/0", out_valid, out_inst, out_pcadd4);
    end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_cnt got=%0d want=0", stall_cnt); end
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_in_ready got=%0b want=1", in_ready); end
    for (int k = 0; k < 2; k++) begin
      tick;
      total++; if (out_valid !== 1'b0 || out_inst !== 32'h0) begin bad++; $display("[TB] FAIL rstmid_no_stale[%0d] got=%0b/%h want=0/00000000", k, out_valid, out_inst); end
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(1'b1, 32'hCD, 32'd600);
    tick;
    drive(1'b1, 32'hCE, 32'd604);
    total++; if (out_valid !== 1'b1 || out_inst !== 32'hCD || out_pcadd4 !== 32'd600) begin
      bad++; $display("[TB] FAIL b2b_first got=%0b/%h/%0d want=1/000000cd/600", out_valid, out_inst, out_pcadd4);
    end
    tick;
    drive(1'b0, 32'h0, 32'h0);
    total++; if (out_valid !== 1'b1 || out_inst !== 32'hCE || out_pcadd4 !== 32'd604) begin
      bad++; $display("[TB] FAIL b2b_second got=%0b/%h/%0d want=1/000000ce/604", out_valid, out_inst, out_pcadd4);
    end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain got=%0b want=0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_stall;
    test_flush;
    test_saturation;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
